pc_sequencer: RTL and testbench

Next-address generator that drives the PC register's 8-bit load input. Each cycle it selects among sequential increment, jump, conditional branch, call, and return, based on the decoded op, the current PC, and a branch flag. It keeps a small return-address stack, and a run/halt/fault state machine. Its output connects directly to the PC register's A input; the PC register's Y output feeds back into PC_IN.

---
 rtl/pc_sequencer_if.sv | 54 +++++
 rtl/pc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//
// Bundles the sequencer's control inputs and status outputs so the sequencer
// and whatever drives it (decode logic, or a bench) connect through a single
// port.
//
// Parameters:
//   AW   address width; must match the PC register width
//   SPW  stack-count width
//
// Signals:
//   PC_IN     current PC (PC register output)
//   OP        decoded op: 000 SEQ, 001 JMP, 010 BRF, 011 CALL, 100 RET, 101 HALT
//   TARGET    jump / branch / call destination
//   FLAG      branch condition for BRF
//   STALL     hold the PC and suppress every stack and state effect
//   NEXT_PC   value the PC register loads at the next clock edge
//   HALTED    high in HALT state
//   FAULT     high in FAULT state
//   OVF       sticky: CALL issued with the stack full
//   UNF       sticky: RET issued with the stack empty
//   SP_COUNT  number of valid return-stack entries
//
// Modports:
//   master  drives the op stream, observes the results
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int AW  = 8,
    parameter int SPW = 3
);
    logic [AW-1:0]  PC_IN;
    logic [2:0]     OP;
    logic [AW-1:0]  TARGET;
    logic           FLAG;
    logic           STALL;
    logic [AW-1:0]  NEXT_PC;
    logic           HALTED;
    logic           FAULT;
    logic           OVF;
    logic           UNF;
    logic [SPW-1:0] SP_COUNT;

    modport master (
        output PC_IN, OP, TARGET, FLAG, STALL,
        input  NEXT_PC, HALTED, FAULT, OVF, UNF, SP_COUNT
    );

    modport slave (
        input  PC_IN, OP, TARGET, FLAG, STALL,
        output NEXT_PC, HALTED, FAULT, OVF, UNF, SP_COUNT
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Next-address generator for the PC register. Every cycle it picks the value
// the PC register loads next: sequential increment, jump, conditional branch,
// call (push return address) or return (pop return address). A small
// run/halt/fault state machine freezes the PC once HALT is executed or the
// return stack is misused.
//
// Build option:
//   PC_STACK_EN  defined   -> return stack, SP_COUNT, OVF and UNF are built.
//                undefined -> no stack storage; CALL acts as JMP, RET acts as
//                             SEQ, OVF/UNF/SP_COUNT read 0, FAULT never set.
//
// Parameters:
//   AW     address width (must match the PC register)
//   DEPTH  return-stack entries, 1..16
//   SPW    stack-count width, clog2(DEPTH+1)
//
// Ports:
//   CLK    rising-edge clock shared with the PC register
//   RESET  asynchronous, active-high reset
//   bus    pc_sequencer_if.slave: PC_IN, OP, TARGET, FLAG, STALL in;
//          NEXT_PC, HALTED, FAULT, OVF, UNF, SP_COUNT out
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = 3
) (
    input  logic           CLK,
    input  logic           RESET,
    pc_sequencer_if.slave  bus
);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRF  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t        state;
    logic          halted_q;
    logic          fault_q;

    logic [AW-1:0] incr;
    logic [AW-1:0] next_pc;
    logic          go_halt;
    logic          go_fault;

    // Wraps naturally at 2^AW: all-ones + 1 becomes 0.
    assign incr = bus.PC_IN + AW'(1);

`ifdef PC_STACK_EN
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  stack_mem [DEPTH];
    logic [SPW-1:0] sp;
    logic           ovf_q;
    logic           unf_q;
    logic           full;
    logic           empty;
    logic [AW-1:0]  top;
    logic           do_push;
    logic           do_pop;
    logic           set_ovf;
    logic           set_unf;

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    // Entries are plain registers, so the top is readable in the same cycle;
    // a CALL followed directly by RET sees the value pushed at the edge between.
    assign top   = empty ? '0 : stack_mem[IW'(sp - SPW'(1))];
`else
    // DEPTH only sizes the return stack; referenced here so the stackless
    // build keeps the same parameter list without an unused parameter.
    logic unused_depth;
    assign unused_depth = (DEPTH > 0);
`endif

    // -------------------------------------------------------------------------
    // Next-address selection and side-effect decode.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        next_pc  = bus.PC_IN;
        go_halt  = 1'b0;
        go_fault = 1'b0;
`ifdef PC_STACK_EN
        do_push  = 1'b0;
        do_pop   = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
`endif
        // STALL outranks every op; HALT/FAULT hold the PC regardless of inputs.
        if (state == ST_RUN && !bus.STALL) begin
            case (bus.OP)
                OP_JMP:  next_pc = bus.TARGET;
                OP_BRF:  next_pc = bus.FLAG ? bus.TARGET : incr;
`ifdef PC_STACK_EN
                OP_CALL: begin
                    if (full) begin
                        set_ovf  = 1'b1;
                        go_fault = 1'b1;
                    end else begin
                        next_pc = bus.TARGET;
                        do_push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        set_unf  = 1'b1;
                        go_fault = 1'b1;
                    end else begin
                        next_pc = top;
                        do_pop  = 1'b1;
                    end
                end
`else
                OP_CALL: next_pc = bus.TARGET;
                OP_RET:  next_pc = incr;
`endif
                OP_HALT: go_halt = 1'b1;
                default: next_pc = incr;   // SEQ and the unused codes 110/111
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Run / halt / fault state machine with registered status outputs.
    // HALT and FAULT are exited only through RESET.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (RESET) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (state == ST_RUN) begin
            if (go_halt) begin
                state    <= ST_HALT;
                halted_q <= 1'b1;
            end else if (go_fault) begin
                state    <= ST_FAULT;
                fault_q  <= 1'b1;
            end
        end
    end

`ifdef PC_STACK_EN
    // -------------------------------------------------------------------------
    // Return stack. Push writes at index sp, pop only moves sp down.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: the stack is a handful of flops rather than a RAM macro, so
            // clearing it on reset is cheap and keeps every entry defined.
            for (int i = 0; i < DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
            sp    <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (do_push) begin
                stack_mem[IW'(sp)] <= incr;
                sp                 <= sp + SPW'(1);
            end else if (do_pop) begin
                sp <= sp - SPW'(1);
            end
            if (set_ovf) ovf_q <= 1'b1;
            if (set_unf) unf_q <= 1'b1;
        end
    end

    assign bus.SP_COUNT = sp;
    assign bus.OVF      = ovf_q;
    assign bus.UNF      = unf_q;
`else
    assign bus.SP_COUNT = '0;
    assign bus.OVF      = 1'b0;
    assign bus.UNF      = 1'b0;
`endif

    // The PC register must load 0 for as long as RESET is held.
    assign bus.NEXT_PC = RESET ? '0 : next_pc;
    assign bus.HALTED  = halted_q;
    assign bus.FAULT   = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. A behavioural reference model (return
// stack held as a queue) predicts every output; the prediction is queued when
// the op is driven and popped for comparison once the outputs have settled,
// mid-cycle, away from the rising edge. Works with PC_STACK_EN defined or not.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int SPW   = 3;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRF  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

`ifdef PC_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    pc_sequencer_if #(.AW(AW), .SPW(SPW)) bus ();

    pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .SPW(SPW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic [AW-1:0]  npc;
        logic           halted;
        logic           fault;
        logic           ovf;
        logic           unf;
        logic [SPW-1:0] sp;
    } obs_t;

    typedef enum int {M_RUN, M_HALT, M_FAULT} mstate_t;

    obs_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    mstate_t       m_state;
    logic [AW-1:0] m_stack[$];
    logic          m_ovf;
    logic          m_unf;
    logic [AW-1:0] last_npc;

    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic void model_reset();
        m_state = M_RUN;
        m_stack.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endfunction

    function automatic obs_t model_out(input logic [2:0] op, input logic [AW-1:0] tgt,
                                       input logic flag, input logic stall,
                                       input logic [AW-1:0] pc);
        obs_t          o;
        logic [AW-1:0] inc;
        inc      = pc + 8'd1;
        o.halted = (m_state == M_HALT);
        o.fault  = (m_state == M_FAULT);
        o.ovf    = m_ovf;
        o.unf    = m_unf;
        o.sp     = SPW'(m_stack.size());
        o.npc    = pc;
        if (RESET) begin
            o.npc = '0;
        end else if (m_state == M_RUN && !stall) begin
            case (op)
                OP_JMP:  o.npc = tgt;
                OP_BRF:  o.npc = flag ? tgt : inc;
                OP_CALL: o.npc = (!STACK_EN || m_stack.size() < DEPTH) ? tgt : pc;
                OP_RET: begin
                    if (!STACK_EN)              o.npc = inc;
                    else if (m_stack.size() > 0) o.npc = m_stack[m_stack.size() - 1];
                    else                        o.npc = pc;
                end
                OP_HALT: o.npc = pc;
                default: o.npc = inc;
            endcase
        end
        return o;
    endfunction

    function automatic void model_step(input logic [2:0] op, input logic stall,
                                       input logic [AW-1:0] pc);
        if (RESET || m_state != M_RUN || stall) return;
        case (op)
            OP_CALL: begin
                if (STACK_EN) begin
                    if (m_stack.size() < DEPTH) begin
                        m_stack.push_back(pc + 8'd1);
                    end else begin
                        m_ovf   = 1'b1;
                        m_state = M_FAULT;
                    end
                end
            end
            OP_RET: begin
                if (STACK_EN) begin
                    if (m_stack.size() > 0) begin
                        void'(m_stack.pop_back());
                    end else begin
                        m_unf   = 1'b1;
                        m_state = M_FAULT;
                    end
                end
            end
            OP_HALT: m_state = M_HALT;
            default: ;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Scoreboard compare: pops one prediction and checks every output.
    // -------------------------------------------------------------------------
    task automatic compare_outputs(input string tag);
        obs_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".next_pc"},  32'(bus.NEXT_PC),  32'(e.npc));
        check({tag, ".halted"},   32'(bus.HALTED),   32'(e.halted));
        check({tag, ".fault"},    32'(bus.FAULT),    32'(e.fault));
        check({tag, ".ovf"},      32'(bus.OVF),      32'(e.ovf));
        check({tag, ".unf"},      32'(bus.UNF),      32'(e.unf));
        check({tag, ".sp_count"}, 32'(bus.SP_COUNT), 32'(e.sp));
    endtask

    // Called just after a falling edge: drive one op, check mid-cycle, then
    // let the rising edge commit it and return at the following falling edge.
    task automatic drive(input string tag, input logic [2:0] op,
                         input logic [AW-1:0] tgt, input logic flag,
                         input logic stall, input logic [AW-1:0] pc);
        obs_t e;
        bus.OP     = op;
        bus.TARGET = tgt;
        bus.FLAG   = flag;
        bus.STALL  = stall;
        bus.PC_IN  = pc;
        e          = model_out(op, tgt, flag, stall, pc);
        last_npc   = e.npc;
        exp_q.push_back(e);
        #2;
        compare_outputs(tag);
        model_step(op, stall, pc);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Asserts RESET between edges, checks the immediate clear with an active
    // JMP on the inputs, and releases it at the next falling edge.
    task automatic do_reset(input string tag);
        RESET      = 1'b1;
        model_reset();
        bus.OP     = OP_JMP;
        bus.TARGET = 8'h77;
        bus.FLAG   = 1'b0;
        bus.STALL  = 1'b0;
        bus.PC_IN  = 8'h55;
        #1;
        exp_q.push_back(model_out(OP_JMP, 8'h77, 1'b0, 1'b0, 8'h55));
        compare_outputs(tag);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] pc;
        bus.OP     = OP_SEQ;
        bus.TARGET = '0;
        bus.FLAG   = 1'b0;
        bus.STALL  = 1'b0;
        bus.PC_IN  = '0;
        model_reset();
        last_npc   = '0;

        #2;
        do_reset("reset0");

        // Sequential increment through the wrap point, fed back as the PC would be.
        pc = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            drive("seq_wrap", OP_SEQ, 8'h00, 1'b0, 1'b0, pc);
            pc = last_npc;
        end

        // CALL then RET on the very next cycle.
        drive("call1",     OP_CALL, 8'h40, 1'b0, 1'b0, 8'h10);
        drive("ret1",      OP_RET,  8'h00, 1'b0, 1'b0, 8'h40);
        drive("after_ret", OP_SEQ,  8'h00, 1'b0, 1'b0, last_npc);

        // Branches, stalled CALL and stalled HALT.
        drive("brf_taken",   OP_BRF,  8'h80, 1'b1, 1'b0, 8'h20);
        drive("brf_not",     OP_BRF,  8'h80, 1'b0, 1'b0, 8'h20);
        drive("call_stall",  OP_CALL, 8'h55, 1'b0, 1'b1, 8'h20);
        drive("halt_stall",  OP_HALT, 8'h00, 1'b0, 1'b1, 8'h20);
        drive("after_stall", OP_JMP,  8'hC3, 1'b0, 1'b0, 8'h20);
        drive("op_111_seq",  3'b111,  8'hAA, 1'b1, 1'b0, 8'h3C);

        // Two-deep LIFO ordering.
        drive("lifo_call_a", OP_CALL, 8'h60, 1'b0, 1'b0, 8'h05);
        drive("lifo_call_b", OP_CALL, 8'h70, 1'b0, 1'b0, 8'h60);
        drive("lifo_ret_b",  OP_RET,  8'h00, 1'b0, 1'b0, 8'h70);
        drive("lifo_ret_a",  OP_RET,  8'h00, 1'b0, 1'b0, last_npc);
        drive("lifo_done",   OP_SEQ,  8'h00, 1'b0, 1'b0, last_npc);

        // Five nested CALLs against a four-entry stack, then ops while faulted.
        pc = 8'h00;
        for (int i = 0; i < 5; i++) begin
            drive("nest_call", OP_CALL, 8'(8'h10 * (i + 1) + 2), 1'b0, 1'b0, pc);
            pc = last_npc;
        end
        drive("post_ovf_seq", OP_SEQ, 8'h00, 1'b0, 1'b0, pc);
        drive("post_ovf_jmp", OP_JMP, 8'h99, 1'b0, 1'b0, pc);
        drive("post_ovf_ret", OP_RET, 8'h00, 1'b0, 1'b0, pc);
        #2;
        do_reset("reset_after_ovf");

        // RET on an empty stack, then reset mid-cycle.
        drive("ret_empty",    OP_RET, 8'h00, 1'b0, 1'b0, 8'h24);
        drive("post_unf",     OP_SEQ, 8'h00, 1'b0, 1'b0, last_npc);
        #2;
        do_reset("reset_after_unf");

        // HALT, then a JMP that must not move the PC.
        drive("halt", OP_HALT, 8'h00, 1'b0, 1'b0, 8'h33);
        for (int i = 0; i < 3; i++) begin
            drive("halted_jmp", OP_JMP, 8'h99, 1'b0, 1'b0, 8'h33);
        end
        #2;
        do_reset("reset_after_halt");

        // Randomised op stream, a reset between batches.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 20; i++) begin
                drive("random", 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      8'($urandom_range(0, 255)));
            end
            #2;
            do_reset("reset_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
